// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decode/datapath control bundle for the multicycle MIPS core
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       i_or_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;

    modport master (
        input  opcode, funct,
        output mem_to_reg, reg_dest, i_or_d, alu_src_a,
        output ir_write, mem_write, pc_write, branch, reg_write,
        output alu_src_b, pc_src, alu_control
    );

    modport slave (
        output opcode, funct,
        input  mem_to_reg, reg_dest, i_or_d, alu_src_a,
        input  ir_write, mem_write, pc_write, branch, reg_write,
        input  alu_src_b, pc_src, alu_control
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with ALU decode and retired counter
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  ctrl,
    output logic [3:0]               state,
    output logic                     illegal,
    output logic [CNT_W-1:0]         retired
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB   = 4'd7,
        BRANCH   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic [1:0] alu_op;
    logic ir_write_s, mem_write_s, pc_write_s, branch_s, reg_write_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d           = FETCH;
        illegal           = 1'b0;
        alu_op            = 2'b00;
        ctrl.mem_to_reg   = 1'b0;
        ctrl.reg_dest     = 1'b0;
        ctrl.i_or_d       = 1'b0;
        ctrl.alu_src_a    = 1'b0;
        ctrl.alu_src_b    = 2'b00;
        ctrl.pc_src       = 2'b00;
        ir_write_s        = 1'b0;
        mem_write_s       = 1'b0;
        pc_write_s        = 1'b0;
        branch_s          = 1'b0;
        reg_write_s       = 1'b0;
        case (state_q)
            FETCH: begin
                state_d        = DECODE;
                ctrl.alu_src_b = 2'b01;
                ir_write_s     = 1'b1;
                pc_write_s     = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                state_d        = (state_q == ADDIEX) ? ADDIWB
                               : (ctrl.opcode == OP_LW) ? MEMREAD : MEMWRITE;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            MEMREAD: begin
                state_d     = MEMWB;
                ctrl.i_or_d = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                reg_write_s     = 1'b1;
            end
            MEMWRITE: begin
                ctrl.i_or_d = 1'b1;
                mem_write_s = 1'b1;
            end
            EXECUTE: begin
                state_d        = ALUWB;
                ctrl.alu_src_a = 1'b1;
                alu_op         = 2'b10;
            end
            ALUWB: begin
                ctrl.reg_dest = 1'b1;
                reg_write_s   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                alu_op         = 2'b01;
                ctrl.pc_src    = 2'b01;
                branch_s       = 1'b1;
            end
            ADDIWB:  reg_write_s = 1'b1;
            JUMP: begin
                ctrl.pc_src = 2'b10;
                pc_write_s  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ctrl.alu_control = 3'b010;
        case (alu_op)
            2'b01: ctrl.alu_control = 3'b110;
            2'b10: begin
                case (ctrl.funct)
                    6'b100010: ctrl.alu_control = 3'b110;
                    6'b100100: ctrl.alu_control = 3'b000;
                    6'b100101: ctrl.alu_control = 3'b001;
                    6'b101010: ctrl.alu_control = 3'b111;
                    default:   ctrl.alu_control = 3'b010;
                endcase
            end
            default: ctrl.alu_control = 3'b010;
        endcase
    end

    // Write enables are masked by reset so nothing in the datapath commits while held.
    assign ctrl.ir_write  = ir_write_s  & rst_n;
    assign ctrl.mem_write = mem_write_s & rst_n;
    assign ctrl.pc_write  = pc_write_s  & rst_n;
    assign ctrl.branch    = branch_s    & rst_n;
    assign ctrl.reg_write = reg_write_s & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (state_q inside {MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP}) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle MIPS core: consumes `opcode` and `funct` from the datapath's instruction register and drives every datapath control input (mux selects, write enables, ALU operation) one state per clock. It is the decode side of the datapath's control interface and connects port-for-port to the datapath's control inputs. It also provides a state debug output, an illegal-opcode flag and a retired-instruction counter.

## Interface

Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock. The design uses a single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `opcode`  in  6  instr[31:26] from the datapath instruction register.
- `funct`  in  6  instr[5:0] from the datapath instruction register.
- `mem_to_reg`, `reg_dest`, `i_or_d`, `alu_src_a`  out  1 each  datapath mux selects.
- `ir_write`, `mem_write`, `pc_write`, `branch`, `reg_write`  out  1 each  datapath enables.
- `alu_src_b`  out  2  ALU B select: 00 = b, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `pc_src`  out  2  PC source: 00 = alu_result, 01 = alu_out, 10 = jump target.
- `alu_control`  out  3  ALU operation code.
- `state`  out  4  current state encoding, for debug.
- `illegal`  out  1  high in DECODE when `opcode` is not supported.
- `retired`  out  CNT_W  count of completed instructions.

## Operation

State encoding:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
- Codes 12–15 are unused. Any unused code goes to FETCH on the next edge.

Transitions:
- FETCH → DECODE.
- DECODE, by `opcode`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other value → FETCH, with `illegal` = 1 during DECODE.
- MEMADR → MEMREAD if lw, MEMWRITE if sw. MEMREAD → MEMWB.
- EXECUTE → ALUWB. ADDIEX → ADDIWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP each → FETCH.

Moore outputs (Moore decode of `state`). Every signal not listed for a state is 0. `alu_op` is internal.
- FETCH: alu_src_b = 01, ir_write = 1, pc_write = 1, alu_op = 00.
- DECODE: alu_src_b = 11, alu_op = 00.
- MEMADR and ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
- MEMREAD: i_or_d = 1.
- MEMWB: mem_to_reg = 1, reg_write = 1.
- MEMWRITE: i_or_d = 1, mem_write = 1.
- EXECUTE: alu_src_a = 1, alu_op = 10.
- ALUWB: reg_dest = 1, reg_write = 1.
- BRANCH: alu_src_a = 1, alu_op = 01, pc_src = 01, branch = 1.
- ADDIWB: reg_write = 1.
- JUMP: pc_src = 10, pc_write = 1.

ALU decode (combinational):
- alu_op 00 → alu_control = 010 (add).
- alu_op 01 → 110 (sub).
- alu_op 10, by `funct`:
  - 100000 → 010 (add).
  - 100010 → 110 (sub).
  - 100100 → 000 (and).
  - 100101 → 001 (or).
  - 101010 → 111 (slt).
  - Any other funct → 010 (add).

Retired counter:
- Increments by 1 on each edge at which `state` is MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP.
- Wraps modulo 2^CNT_W.
- An illegal opcode is not counted.

## Timing

- Reset (`rst_n` = 0):
  - `state` is forced to FETCH and `retired` to 0, asynchronously.
  - While `rst_n` = 0, `ir_write`, `pc_write`, `mem_write`, `reg_write` and `branch` are forced to 0 combinationally.
  - All other outputs show the FETCH values.
- First fetch: occurs on the first rising edge after `rst_n` rises.
- Reset asserted mid-instruction: aborts the instruction with no further writes. The instruction is not counted.
- Instruction latency in cycles, FETCH through last state:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Illegal opcode: 2 (FETCH, DECODE).
- `opcode` and `funct` are sampled only in DECODE/MEMADR (`opcode`) and EXECUTE (`funct`). They are stable because `ir_write` is 0 outside FETCH.
- Output timing: all outputs are glitch-free functions of registered state and the stable instruction fields. There is no output register stage.

## Test plan

- **Reset release, then lw** (opcode 100011): `state` sequence 0,1,2,3,4,0.
  - `ir_write` and `pc_write` are 1 only in cycle 0.
  - MEMWB shows `mem_to_reg` = 1 and `reg_write` = 1.
  - `retired` goes 0 → 1.
- **R-type, funct 100010 then 101010** (two instructions): EXECUTE shows `alu_control` 110, then 111.
  - ALUWB shows `reg_dest` = 1 and `reg_write` = 1.
  - Each instruction takes 4 cycles. `retired` = 2.
- **sw, then beq, then j**:
  - MEMWRITE shows `i_or_d` = 1 and `mem_write` = 1.
  - BRANCH shows `branch` = 1, `pc_src` = 01, `alu_control` = 110.
  - JUMP shows `pc_src` = 10 and `pc_write` = 1.
  - Sequence lengths 4, 3, 3 cycles. `retired` increments by 3.
- **addi, then opcode 111111**:
  - ADDIEX shows `alu_src_b` = 10. ADDIWB shows `reg_write` = 1 and `reg_dest` = 0.
  - The illegal opcode gives `illegal` = 1 in DECODE, then returns to FETCH.
  - `retired` increments by 1 only.
- **Reset mid-lw**: drive `rst_n` low while in MEMREAD.
  - `state` goes to 0 immediately, without waiting for an edge.
  - All enables are 0 while reset is held. `retired` = 0.
  - After release, fetch resumes normally.
- **Counter wrap** (CNT_W = 4): 17 R-type instructions → `retired` = 1.
